// File: rtl/serial_digit_addsub.sv
// ============================================================================
// serial_digit_addsub: digit-serial two's-complement adder/subtractor, LSD first.
// Rev 1.0
// ============================================================================
`default_nettype none

module serial_digit_addsub #(
  parameter int W          = 4,
  parameter int MAX_DIGITS = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic         in_first,
  input  logic         in_last,
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  output logic [W-1:0] out_sum,
  output logic         out_last,
  output logic         out_carry,
  output logic         out_ovf,
  output logic         frame_err
);

  localparam int c_CNT_W = $clog2(MAX_DIGITS + 1);
  localparam logic [c_CNT_W-1:0] c_MAX = c_CNT_W'(MAX_DIGITS);
  localparam logic [c_CNT_W-1:0] c_ONE = c_CNT_W'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t               r_state;
  logic                 r_carry;
  logic                 r_sub_mode;
  logic [c_CNT_W-1:0]   r_cnt;

  logic                 w_start;
  logic                 w_cont;
  logic                 w_proc;
  logic                 w_overlen;
  logic                 w_sub_eff;
  logic                 w_cin;
  logic [W-1:0]         w_b_eff;
  logic [W-1:0]         w_sum;
  logic [W:0]           w_c;
  logic                 w_ovf;

  assign w_start   = in_valid & in_first;
  assign w_overlen = in_valid & ~in_first & (r_state == S_BUSY) & (r_cnt >= c_MAX);
  assign w_cont    = in_valid & ~in_first & (r_state == S_BUSY) & (r_cnt < c_MAX);
  assign w_proc    = w_start | w_cont;

  // A first digit uses the live sub input both for inversion and carry-in.
  assign w_sub_eff = in_first ? sub : r_sub_mode;
  assign w_cin     = in_first ? sub : r_carry;
  assign w_b_eff   = b ^ {W{w_sub_eff}};

  assign w_c[0] = w_cin;
  for (genvar gi = 0; gi < W; gi++) begin : g_fa
    assign w_sum[gi]  = a[gi] ^ w_b_eff[gi] ^ w_c[gi];
    assign w_c[gi+1]  = (a[gi] & w_b_eff[gi]) | (w_c[gi] & (a[gi] ^ w_b_eff[gi]));
  end
  assign w_ovf = w_c[W] ^ w_c[W-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_carry    <= 1'b0;
      r_sub_mode <= 1'b0;
      r_cnt      <= '0;
      out_valid  <= 1'b0;
      out_sum    <= '0;
      out_last   <= 1'b0;
      out_carry  <= 1'b0;
      out_ovf    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_carry <= 1'b0;
      out_ovf   <= 1'b0;
      frame_err <= 1'b0;
      if (w_proc) begin
        out_valid <= 1'b1;
        out_sum   <= w_sum;
        r_carry   <= w_c[W];
        if (in_first) begin
          r_sub_mode <= sub;
          r_cnt      <= c_ONE;
          // Restart inside a word abandons the old one.
          frame_err  <= (r_state == S_BUSY);
        end else begin
          r_cnt <= r_cnt + c_ONE;
        end
        if (in_last) begin
          out_last  <= 1'b1;
          out_carry <= w_c[W];
          out_ovf   <= w_ovf;
          r_state   <= S_IDLE;
          r_carry   <= 1'b0;
        end else begin
          r_state <= S_BUSY;
        end
      end else if (in_valid) begin
        frame_err <= 1'b1;
        if (w_overlen) begin
          r_state <= S_IDLE;
          r_carry <= 1'b0;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_digit_addsub.sv
// ============================================================================
// tb_serial_digit_addsub: directed + random checks against a word-level model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_serial_digit_addsub;

  localparam int W    = 4;
  localparam int MAXD = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_first, in_last, sub;
  logic [W-1:0] a, b;
  logic         out_valid, out_last, out_carry, out_ovf, frame_err;
  logic [W-1:0] out_sum;

  int checks = 0;
  int errors = 0;

  // Word-level model state: operands accumulated as plain integers.
  bit              m_busy;
  int              m_n;
  bit              m_sub;
  longint unsigned m_A, m_B;

  bit         e_valid, e_last, e_carry, e_ovf, e_ferr;
  logic [3:0] e_sum;

  serial_digit_addsub #(.W(W), .MAX_DIGITS(MAXD)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .sub(sub), .a(a), .b(b), .out_valid(out_valid),
    .out_sum(out_sum), .out_last(out_last), .out_carry(out_carry),
    .out_ovf(out_ovf), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_process(input bit l);
    int              bits;
    longint unsigned mask, beff, s;
    bit              sa, sb, sr;
    bits = m_n * W;
    mask = (64'd1 << bits) - 64'd1;
    beff = m_sub ? (~m_B & mask) : m_B;
    s    = m_A + beff + longint'(m_sub);
    e_valid = 1'b1;
    e_sum   = 4'((s >> ((m_n - 1) * W)) & 64'hF);
    if (l) begin
      sa = m_A[bits-1];
      sb = beff[bits-1];
      sr = s[bits-1];
      e_last  = 1'b1;
      e_carry = s[bits];
      e_ovf   = (sa == sb) && (sr != sa);
      m_busy  = 1'b0;
    end else begin
      m_busy = 1'b1;
    end
  endtask

  task automatic model_digit(input bit v, f, l, s, input logic [3:0] av, bv);
    e_valid = 0; e_last = 0; e_carry = 0; e_ovf = 0; e_ferr = 0; e_sum = 'x;
    if (v) begin
      if (f) begin
        e_ferr = m_busy;
        m_sub  = s;
        m_A    = longint'(av);
        m_B    = longint'(bv);
        m_n    = 1;
        model_process(l);
      end else if (!m_busy) begin
        e_ferr = 1'b1;
      end else if (m_n >= MAXD) begin
        e_ferr = 1'b1;
        m_busy = 1'b0;
      end else begin
        m_A = m_A | (longint'(av) << (m_n * W));
        m_B = m_B | (longint'(bv) << (m_n * W));
        m_n++;
        model_process(l);
      end
    end
  endtask

  // Drive one cycle of input, then check the registered response.
  task automatic step(input bit v, f, l, s, input logic [3:0] av, bv);
    in_valid = v; in_first = f; in_last = l; sub = s; a = av; b = bv;
    model_digit(v, f, l, s, av, bv);
    @(posedge clk);
    #1;
    check("out_valid", 32'(out_valid), 32'(e_valid));
    if (e_valid) check("out_sum", 32'(out_sum), 32'(e_sum));
    check("out_last", 32'(out_last), 32'(e_last));
    check("out_carry", 32'(out_carry), 32'(e_carry));
    check("out_ovf", 32'(out_ovf), 32'(e_ovf));
    check("frame_err", 32'(frame_err), 32'(e_ferr));
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 4'h0, 4'h0);
  endtask

  task automatic check_reset_outputs();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(out_sum), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_carry", 32'(out_carry), 32'd0);
    check("rst_ovf", 32'(out_ovf), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
  endtask

  initial begin
    int len;
    bit ws;
    rst = 1'b0; in_valid = 0; in_first = 0; in_last = 0; sub = 0; a = 0; b = 0;
    m_busy = 0; m_n = 0; m_sub = 0; m_A = 0; m_B = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b1;

    // 0x1234 + 0x0FFF
    step(1, 1, 0, 0, 4'h4, 4'hF);
    check("t1_d0", 32'(out_sum), 32'h3);
    step(1, 0, 0, 0, 4'h3, 4'hF);
    step(1, 0, 0, 0, 4'h2, 4'hF);
    step(1, 0, 1, 0, 4'h1, 4'h0);
    check("t1_d3", 32'(out_sum), 32'h2);
    idle();

    // 0x0010 - 0x0001, sub only on the first digit
    step(1, 1, 0, 1, 4'h0, 4'h1);
    check("t2_d0", 32'(out_sum), 32'hF);
    step(1, 0, 0, 0, 4'h1, 4'h0);
    step(1, 0, 0, 0, 4'h0, 4'h0);
    step(1, 0, 1, 0, 4'h0, 4'h0);
    check("t2_carry", 32'(out_carry), 32'd1);

    // Single-digit words
    step(1, 1, 1, 0, 4'h7, 4'h1);
    check("sd_add_ovf", 32'(out_ovf), 32'd1);
    step(1, 1, 1, 1, 4'h0, 4'h1);
    check("sd_sub_sum", 32'(out_sum), 32'hF);
    step(1, 1, 1, 0, 4'hF, 4'h1);
    check("sd_wrap_carry", 32'(out_carry), 32'd1);
    idle();

    // Framing: non-first digit while idle
    step(1, 0, 0, 0, 4'h5, 4'h5);
    idle();
    // Restart after two digits
    step(1, 1, 0, 0, 4'hF, 4'hF);
    step(1, 0, 0, 0, 4'hF, 4'hF);
    step(1, 1, 0, 0, 4'h1, 4'h2);
    check("restart_both", 32'({frame_err, out_valid}), 32'b11);
    step(1, 0, 1, 0, 4'h0, 4'h0);
    idle();

    // Length limit: nine digits without in_last
    step(1, 1, 0, 0, 4'h9, 4'h8);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 4'(i), 4'hC);
    idle();
    step(1, 1, 0, 1, 4'h3, 4'h5);
    step(1, 0, 1, 0, 4'h8, 4'h1);
    idle();

    // Mid-word reset with carry pending
    step(1, 1, 0, 0, 4'hF, 4'h1);
    step(1, 0, 0, 0, 4'hF, 4'h1);
    rst = 1'b0;
    #1;
    check_reset_outputs();
    m_busy = 0;
    in_valid = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(1, 1, 0, 0, 4'h1, 4'h1);
    check("post_rst_d0", 32'(out_sum), 32'h2);
    step(1, 0, 1, 0, 4'h0, 4'h0);
    check("post_rst_d1", 32'(out_sum), 32'h0);

    // Gapped word
    step(1, 1, 0, 0, 4'h4, 4'hF);
    idle();
    step(1, 0, 0, 0, 4'h3, 4'hF);
    idle();
    idle();
    step(1, 0, 0, 0, 4'h2, 4'hF);
    step(1, 0, 1, 0, 4'h1, 4'h0);
    check("gap_last", 32'(out_sum), 32'h2);

    // Random words with gaps and occasional framing faults
    for (int w = 0; w < 60; w++) begin
      len = int'($urandom_range(1, MAXD + 1));
      ws  = 1'($urandom);
      for (int d = 0; d < len; d++) begin
        if ($urandom_range(0, 3) == 0) idle();
        step(1, (d == 0) || ($urandom_range(0, 24) == 0),
             (d == len - 1) && (len <= MAXD) && ($urandom_range(0, 9) != 0),
             (d == 0) ? ws : 1'($urandom), 4'($urandom), 4'($urandom));
      end
      if ($urandom_range(0, 2) == 0) idle();
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_digit_addsub.md
Name: serial_digit_addsub

Overview:
- Digit-serial two's-complement adder/subtractor: a parametrised successor to the 1-bit serial adder.
- Consumes operands W bits per cycle, least-significant digit first, framed by first/last flags. Emits one registered sum digit per accepted digit.
- Carry is held between digits. Reports word carry-out, signed overflow and framing errors.
- Sits between serialisers and downstream digit-serial arithmetic.

Parameters:
- W, default 4: digit width in bits, W >= 1.
- MAX_DIGITS, default 8: maximum digits per word, >= 1. Digit counter width is $clog2(MAX_DIGITS+1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- in_valid  input  1  digit present this cycle. No backpressure; the block is always ready.
- in_first  input  1  digit is the least-significant digit of a word.
- in_last  input  1  digit is the most-significant digit of a word.
- sub  input  1  mode, sampled only with in_first: 0 = a+b, 1 = a-b.
- a  input  W  operand A digit.
- b  input  W  operand B digit.
- out_valid  output  1  sum digit valid.
- out_sum  output  W  sum digit.
- out_last  output  1  out_sum is the word's MS digit.
- out_carry  output  1  carry-out of MS bit. Valid with out_last; 0 otherwise. For sub, 1 = no borrow.
- out_ovf  output  1  signed overflow (carry into MSB ^ carry out of MSB). Valid with out_last; 0 otherwise.
- frame_err  output  1  one-cycle pulse on a framing violation.

Behaviour:
- Arithmetic: b_eff = sub_mode ? ~b : b.
- Arithmetic: the digit sum is a W-bit ripple of full-adder cells built only from ^, &, |, ~. The + and - operators are forbidden in the datapath.
- Arithmetic: carry-in is sub (the live input) on an in_first digit; otherwise it is the carry register.
- State: carry reg, sub_mode reg, digit counter, FSM {IDLE, BUSY}.
- Outputs are all registered. Latency is 1 cycle from accepted digit to out_valid.
- Reset (rst=0, async): FSM=IDLE; carry, sub_mode and counter = 0; all outputs = 0. Takes effect immediately, also mid-word; the partial word is discarded.
- IDLE, in_valid & in_first:
  - sub_mode <= sub; process the digit; counter <= 1.
  - If in_last: emit with out_last=1 and stay IDLE. Otherwise go to BUSY.
- IDLE, in_valid & !in_first: digit dropped, no out_valid, frame_err=1 next cycle.
- BUSY, in_valid & !in_first: process with the carry register; counter++.
  - If in_last: emit with out_last, out_carry, out_ovf; go to IDLE and clear carry.
- BUSY, in_valid & in_first: frame_err=1. The old word is abandoned with no out_last emitted. The new digit is processed as a fresh first digit, with the same handling as in IDLE.
- Length limit: a digit that would be number MAX_DIGITS+1 of a word is dropped (no out_valid); frame_err=1; go to IDLE. This only applies if the MAX_DIGITS-th digit did not carry in_last.
- in_valid=0: state holds; out_valid=0; out_carry, out_ovf and out_last = 0. Gaps between digits are allowed.
- The carry register updates only on processed digits. sub is ignored on non-first digits.
- frame_err and out_valid can both be 1 in the same cycle (the restart case).

Test Plan:
- Add 0x1234 + 0x0FFF (W=4), digits a=4,3,2,1 b=F,F,F,0, sub=0 -> out_sum 3,3,2,2, out_last on the 4th digit, out_carry=0, out_ovf=0, each output 1 cycle after its input.
- Sub 0x0010 - 0x0001, digits a=0,1,0,0 b=1,0,0,0, sub=1 on the first digit only (0 afterwards) -> out_sum F,0,0,0; out_carry=1; out_ovf=0.
- Single-digit words, first=last=1:
  - add a=7,b=1 -> sum 8, carry 0, ovf 1.
  - sub a=0,b=1 -> sum F, carry 0, ovf 0.
  - add a=F,b=1 -> sum 0, carry 1, ovf 0.
- Framing:
  - in_valid without first in IDLE -> no out_valid, frame_err pulse.
  - in_first after 2 digits of a word -> frame_err and out_valid together; the new word sums correctly from a fresh carry.
- Length limit, MAX_DIGITS=8: 9 digits, no in_last -> 8 outputs, 9th dropped with frame_err, FSM back to IDLE. The next framed word is correct.
- Reset and gaps:
  - Mid-word reset after 2 digits with carry=1 -> outputs 0 immediately; the next word 0x0001+0x0001 gives 2,0 with no stale carry.
  - Insert in_valid=0 gaps mid-word -> results identical to the gapless case.
